// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains BURST_LEN-word bursts from an async FIFO
// read port into a registered valid/ready stream once a grant is held.
//
// Ports:
//   rd_clk, rd_rst       : read clock, async active-high reset
//   fifo_rd_en           : pop strobe to the FIFO
//   fifo_rd_data         : FIFO read data
//   fifo_empty           : FIFO empty flag
//   fifo_rd_data_count   : FIFO occupancy in read words
//   burst_req, burst_ack : downstream burst slot request / grant
//   m_valid, m_ready     : stream handshake
//   m_data, m_last       : stream payload, final-word marker
//   busy                 : any state other than IDLE
//   burst_done           : one-cycle pulse after the final handshake
//
// Build option: FIFO_FWFT_EN selects a first-word-fall-through FIFO;
// left undefined, read data arrives one cycle after the pop.

module fifo_burst_reader #(
  parameter int RD_WIDTH        = 32,
  parameter int RD_CNT_WIDTH    = 11,
  parameter int BURST_LEN       = 16,
  parameter int BURST_CNT_WIDTH = 5
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst,
  output logic                    fifo_rd_en,
  input  logic [RD_WIDTH-1:0]     fifo_rd_data,
  input  logic                    fifo_empty,
  input  logic [RD_CNT_WIDTH-1:0] fifo_rd_data_count,
  output logic                    burst_req,
  input  logic                    burst_ack,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [RD_WIDTH-1:0]     m_data,
  output logic                    m_last,
  output logic                    busy,
  output logic                    burst_done
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    DONE
  } state_t;

  localparam logic [BURST_CNT_WIDTH-1:0] BL_C =
    BURST_CNT_WIDTH'(BURST_LEN);
  localparam logic [RD_CNT_WIDTH-1:0] BL_CNT =
    RD_CNT_WIDTH'(BURST_LEN);
  localparam logic [BURST_CNT_WIDTH-1:0] ONE_C =
    BURST_CNT_WIDTH'(1);

  state_t                     state;
  logic [BURST_CNT_WIDTH-1:0] rd_remain;
  logic [BURST_CNT_WIDTH-1:0] tx_remain;

  // m_data/m_valid form the head entry, skid holds the second one
  logic [1:0]          occ;
  logic [RD_WIDTH-1:0] skid;

  logic       inflight;
  logic       cap;
  logic       hs;
  logic [2:0] pend;
  logic       credit;

`ifdef FIFO_FWFT_EN
  // Data is presented with the pop, so nothing is ever outstanding
  assign inflight = 1'b0;
  assign cap      = fifo_rd_en;
`else
  // One pop may be outstanding; its data lands on the next edge
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end
  assign cap = inflight;
`endif

  assign hs   = m_valid & m_ready;
  assign pend = {1'b0, occ} + {2'b00, inflight};

  // A slot freed by this cycle's handshake may be reused at once,
  // which keeps one word per cycle flowing with m_ready high
  assign credit = pend < (3'd2 + {2'b00, hs});

  assign fifo_rd_en = (state == XFER)
                    & (rd_remain != '0)
                    & ~fifo_empty
                    & credit;

  assign m_last = m_valid & (tx_remain == ONE_C);

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      occ     <= 2'd0;
      m_valid <= 1'b0;
      m_data  <= '0;
      skid    <= '0;
    end else begin
      unique case (occ)
        2'd0: begin
          if (cap) begin
            m_data  <= fifo_rd_data;
            m_valid <= 1'b1;
            occ     <= 2'd1;
          end
        end
        2'd1: begin
          if (hs && cap) begin
            m_data <= fifo_rd_data;
          end else if (hs) begin
            m_valid <= 1'b0;
            occ     <= 2'd0;
          end else if (cap) begin
            skid <= fifo_rd_data;
            occ  <= 2'd2;
          end
        end
        2'd2: begin
          // credit forbids a capture here unless the head leaves
          if (hs) begin
            m_data <= skid;
            if (cap) begin
              skid <= fifo_rd_data;
            end else begin
              occ <= 2'd1;
            end
          end
        end
        default: begin
          occ <= 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state      <= IDLE;
      burst_req  <= 1'b0;
      busy       <= 1'b0;
      burst_done <= 1'b0;
      rd_remain  <= '0;
      tx_remain  <= '0;
    end else begin
      if (fifo_rd_en) begin
        rd_remain <= rd_remain - ONE_C;
      end
      if (hs && (tx_remain != '0)) begin
        tx_remain <= tx_remain - ONE_C;
      end
      unique case (state)
        IDLE: begin
          if (fifo_rd_data_count >= BL_CNT) begin
            state     <= REQ;
            burst_req <= 1'b1;
            busy      <= 1'b1;
          end
        end
        REQ: begin
          if (burst_ack) begin
            state     <= XFER;
            burst_req <= 1'b0;
            rd_remain <= BL_C;
            tx_remain <= BL_C;
          end
        end
        XFER: begin
          if (hs && (tx_remain == ONE_C)) begin
            state      <= DONE;
            burst_done <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          burst_done <= 1'b0;
          busy       <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: drives fifo_burst_reader from a queue-based
// FIFO model and scores the stream against the words actually popped.

module tb_fifo_burst_reader;

  localparam int BL = 16;
`ifdef FIFO_FWFT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        rd_clk = 1'b0;
  logic        rd_rst = 1'b1;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data = '0;
  logic        fifo_empty = 1'b1;
  logic [10:0] fifo_rd_data_count = '0;
  logic        burst_req;
  logic        burst_ack = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;
  logic        burst_done;

  fifo_burst_reader #(
    .RD_WIDTH       (32),
    .RD_CNT_WIDTH   (11),
    .BURST_LEN      (BL),
    .BURST_CNT_WIDTH(5)
  ) dut (
    .rd_clk            (rd_clk),
    .rd_rst            (rd_rst),
    .fifo_rd_en        (fifo_rd_en),
    .fifo_rd_data      (fifo_rd_data),
    .fifo_empty        (fifo_empty),
    .fifo_rd_data_count(fifo_rd_data_count),
    .burst_req         (burst_req),
    .burst_ack         (burst_ack),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_data            (m_data),
    .m_last            (m_last),
    .busy              (busy),
    .burst_done        (burst_done)
  );

  always #5 rd_clk = ~rd_clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // FIFO model and scoreboard
  logic [31:0] q[$];
  logic [31:0] exp_q[$];
  logic [31:0] lasts[$];
  logic        gap = 1'b0;
  logic        pop_req = 1'b0;

  task automatic refresh();
    fifo_empty = gap || (q.size() == 0);
    fifo_rd_data_count = 11'(q.size());
`ifdef FIFO_FWFT_EN
    fifo_rd_data = (q.size() != 0) ? q[0] : '0;
`endif
  endtask

  task automatic push(input logic [31:0] w);
    q.push_back(w);
    refresh();
  endtask

  always begin
    @(posedge rd_clk);
    #1;
    if (pop_req) begin
      logic [31:0] w;
      w = q.pop_front();
      exp_q.push_back(w);
`ifndef FIFO_FWFT_EN
      fifo_rd_data = w;
`endif
      pop_req = 1'b0;
    end
    refresh();
  end

  // Stream-side drivers
  int          rmode = 0;
  int          pidx = 0;
  logic [3:0]  pat = 4'b1001;
  int          ack_dly = 2;
  int          req_cyc = 0;

  always begin
    @(posedge rd_clk);
    #1;
    case (rmode)
      1: begin
        m_ready = pat[3 - pidx];
        pidx = (pidx + 1) % 4;
      end
      2: begin
        m_ready = 1'($urandom_range(0, 1));
        gap = ($urandom_range(0, 7) == 0);
        refresh();
      end
      default: m_ready = 1'b1;
    endcase
    if (burst_req && !burst_ack) begin
      req_cyc++;
      if (req_cyc >= ack_dly) burst_ack = 1'b1;
    end else begin
      burst_ack = 1'b0;
      req_cyc = 0;
    end
  end

  // Monitor, sampled on the falling edge
  int cyc = 0;
  int n_pops = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int req_hi = 0;
  int beat = 0;
  int hs_first = 0;
  int hs_last = 0;
  int pop_cyc = 0;
  logic hold_pend = 1'b0;
  logic prev_done = 1'b0;
  logic got_pop = 1'b0;
  logic got_val = 1'b0;

  always @(negedge rd_clk) begin
    cyc++;
    if (!rd_rst) begin
      pop_req = fifo_rd_en;
      if (fifo_rd_en) begin
        n_pops++;
        check("pop_when_empty", fifo_empty, 0);
        if (!got_pop) begin
          got_pop = 1'b1;
          pop_cyc = cyc;
        end
      end
      if (m_valid) begin
        if (!got_val) begin
          got_val = 1'b1;
          check("first_valid_lat", cyc - pop_cyc, LAT);
        end
        if (exp_q.size() == 0) begin
          check("word_without_pop", 1, 0);
        end else begin
          check("m_data", m_data, exp_q[0]);
        end
        check("m_last", m_last, beat == BL - 1);
      end
      if (hold_pend) check("valid_hold", m_valid, 1);
      hold_pend = m_valid & ~m_ready;
      if (m_valid && m_ready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        hs_cnt++;
        if (beat == 0) hs_first = cyc;
        if (m_last) begin
          hs_last = cyc;
          lasts.push_back(m_data);
        end
        beat = (beat + 1) % BL;
      end
      if (burst_done) begin
        done_cnt++;
        check("busy_in_done", busy, 1);
        got_pop = 1'b0;
        got_val = 1'b0;
      end
      if (prev_done) check("busy_drop", busy, 0);
      prev_done = burst_done;
      if (burst_req) req_hi++;
    end
  end

  task automatic wait_done(input int target, input int lim);
    int k;
    k = 0;
    while (done_cnt < target && k < lim) begin
      @(posedge rd_clk);
      k++;
    end
    #1;
    check("done_count", done_cnt, target);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask

  initial begin
    int h0;
    int p0;
    int d0;
    int k;
    refresh();
    repeat (3) @(negedge rd_clk);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_req", burst_req, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", burst_done, 0);
    #1 rd_rst = 1'b0;
    idle_cycles(2);

    // single burst, ready high, grant after 2 cycles
    rmode = 0;
    ack_dly = 2;
    req_hi = 0;
    h0 = hs_cnt;
    p0 = n_pops;
    for (int i = 0; i < 16; i++) push(32'(i));
    wait_done(1, 200);
    idle_cycles(3);
    check("t1_hs", hs_cnt - h0, 16);
    check("t1_pops", n_pops - p0, 16);
    check("t1_req_cycles", req_hi, 2);
    check("t1_span", hs_last - hs_first, BL - 1);
    check("t1_fifo_left", q.size(), 0);
    check("t1_busy", busy, 0);

    // 15 words must not start a burst; the 16th does
    rmode = 1;
    pidx = 0;
    ack_dly = $urandom_range(1, 4);
    h0 = hs_cnt;
    p0 = n_pops;
    for (int i = 0; i < 15; i++) push(32'(i));
    idle_cycles(8);
    @(negedge rd_clk);
    check("t2_no_req", burst_req, 0);
    check("t2_idle", busy, 0);
    @(posedge rd_clk);
    #1 push(32'h0F);
    @(posedge rd_clk);
    @(negedge rd_clk);
    check("t2_req", burst_req, 1);
    wait_done(2, 300);
    check("t2_hs", hs_cnt - h0, 16);
    check("t2_pops", n_pops - p0, 16);

    // writer stall after word 7
    rmode = 0;
    ack_dly = $urandom_range(1, 4);
    h0 = hs_cnt;
    p0 = n_pops;
    for (int i = 0; i < 16; i++) push(32'(i));
    k = 0;
    while (n_pops < p0 + 8 && k < 200) begin
      @(posedge rd_clk);
      #1;
      k++;
    end
    check("t3_reach_w7", n_pops - p0, 8);
    gap = 1'b1;
    refresh();
    d0 = n_pops;
    repeat (4) @(posedge rd_clk);
    @(negedge rd_clk);
    check("t3_gap_pops", n_pops, d0);
    check("t3_gap_valid", m_valid, 0);
    check("t3_gap_busy", busy, 1);
    @(posedge rd_clk);
    #1;
    gap = 1'b0;
    refresh();
    wait_done(3, 200);
    check("t3_hs", hs_cnt - h0, 16);

    // 40 words: two bursts back to back, 8 left behind
    lasts.delete();
    ack_dly = $urandom_range(1, 3);
    for (int i = 0; i < 40; i++) push(32'(i));
    wait_done(5, 400);
    idle_cycles(10);
    check("t4_left", q.size(), 8);
    check("t4_no_req", burst_req, 0);
    check("t4_nlast", lasts.size(), 2);
    if (lasts.size() == 2) begin
      check("t4_last0", lasts[0], 32'h0F);
      check("t4_last1", lasts[1], 32'h1F);
    end

    // reset in the middle of a burst
    for (int i = 40; i < 64; i++) push(32'(i));
    h0 = hs_cnt;
    d0 = done_cnt;
    k = 0;
    while (hs_cnt < h0 + 5 && k < 200) begin
      @(negedge rd_clk);
      k++;
    end
    check("t5_reach_hs", hs_cnt - h0, 5);
    #1;
    rd_rst = 1'b1;
    pop_req = 1'b0;
    #1;
    check("t5_rd_en", fifo_rd_en, 0);
    check("t5_req", burst_req, 0);
    check("t5_valid", m_valid, 0);
    check("t5_data", m_data, 0);
    check("t5_last", m_last, 0);
    check("t5_busy", busy, 0);
    check("t5_done", burst_done, 0);
    exp_q.delete();
    beat = 0;
    hold_pend = 1'b0;
    prev_done = 1'b0;
    got_pop = 1'b0;
    got_val = 1'b0;
    repeat (2) @(negedge rd_clk);
    #1 rd_rst = 1'b0;
    check("t5_no_done", done_cnt, d0);
    k = 0;
    while (!burst_req && k < 20) begin
      @(negedge rd_clk);
      k++;
    end
    check("t5_rereq", burst_req, 1);
    wait_done(d0 + 1, 300);
    idle_cycles(5);
    check("t5_tail", q.size() < BL, 1);

    // randomized rounds: random data, ready and stalls
    for (int r = 0; r < 6; r++) begin
      int n;
      int tot;
      rmode = 2;
      ack_dly = $urandom_range(1, 5);
      n = $urandom_range(16, 40);
      tot = q.size() + n;
      d0 = done_cnt;
      for (int i = 0; i < n; i++) push($urandom);
      wait_done(d0 + tot / BL, 250 * (tot / BL) + 50);
      rmode = 0;
      gap = 1'b0;
      refresh();
      idle_cycles(6);
      check("rnd_left", q.size(), tot % BL);
      check("rnd_no_req", burst_req, 0);
      check("rnd_sb_empty", exp_q.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
